ones_count_sequencer: RTL and testbench

//  Sequences the 3-input CMOS ones-counter cell (inputs a,b,c; 2-bit result {y1,y0}).

---
 rtl/ones_count_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_ones_count_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ones_count_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ones_count_sequencer
// Description : Sequences a 3-input ones-counter cell (a,b,c -> {y1,y0}).
//               A WIDTH-bit word is accepted over valid/ready and cut into
//               3-bit groups (top group zero-padded). Each group is driven
//               onto the cell, held for SETTLE+1 edges so the cell output
//               settles, then sampled. The samples are summed and the total
//               ones count is returned over valid/ready.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH   input word width (>= 3)
//   SETTLE  cycles a group is held before it is sampled (>= 1)
// Optional feature
//   ONES_CHECK_EN  when defined, adds a sticky err output that is set when
//                  a sampled cell result disagrees with the popcount of the
//                  group being driven. When undefined, no err port exists.
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      word offered
//   in_ready   out  1      sequencer can accept a word (IDLE only)
//   in_data    in   WIDTH  word to count
//   cnt_a      out  1      cell input a: group bit 3k
//   cnt_b      out  1      cell input b: group bit 3k+1
//   cnt_c      out  1      cell input c: group bit 3k+2
//   cnt_y1     in   1      cell result MSB
//   cnt_y0     in   1      cell result LSB
//   out_valid  out  1      out_count valid
//   out_ready  in   1      consumer takes the result
//   out_count  out  CW     total ones in the word, CW = $clog2(WIDTH+1)
//   busy       out  1      high while a group is being driven or sampled
//   err        out  1      sticky cell mismatch flag (ONES_CHECK_EN only)
// ============================================================================
module ones_count_sequencer #(
  parameter int WIDTH  = 12,
  parameter int SETTLE = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       cnt_a,
  output logic                       cnt_b,
  output logic                       cnt_c,
  input  logic                       cnt_y1,
  input  logic                       cnt_y0,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH+1)-1:0] out_count,
  output logic                       busy
`ifdef ONES_CHECK_EN
  ,
  output logic                       err
`endif
);

  // --------------------------------------------------------------------------
  // Derived sizes
  // --------------------------------------------------------------------------
  localparam int G  = (WIDTH + 2) / 3;                     // number of groups
  localparam int CW = $clog2(WIDTH + 1);                   // count width
  localparam int PW = 3 * G;                               // padded width
  localparam int IW = (G > 1) ? $clog2(G) : 1;             // group index width
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;   // settle counter width

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t          state_q,     state_d;
  logic [PW-1:0]   shift_q,     shift_d;     // groups still to be driven
  logic [2:0]      grp_q,       grp_d;       // group on the cell, {c,b,a}
  logic [SW-1:0]   settle_q,    settle_d;
  logic [IW-1:0]   idx_q,       idx_d;
  logic [CW-1:0]   acc_q,       acc_d;
  logic [CW-1:0]   count_q,     count_d;
  logic            in_ready_q,  in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q,      busy_d;

  logic [PW-1:0]   w_padded;
  logic [CW-1:0]   w_sample;
  logic            w_last;

  // Zero-extension pads the top group when WIDTH is not a multiple of 3.
  assign w_padded = PW'(in_data);
  // The cell result is taken as an unsigned 0..3 value; 2'b11 counts as 3
  // and X/Z on the cell pins flows straight into the sum.
  assign w_sample = CW'({cnt_y1, cnt_y0});
  assign w_last   = (idx_q == IW'(G - 1));

`ifdef ONES_CHECK_EN
  logic       err_q, err_d;
  logic [1:0] w_grp_ones;

  assign w_grp_ones = {1'b0, grp_q[0]} + {1'b0, grp_q[1]} + {1'b0, grp_q[2]};
`endif

  // --------------------------------------------------------------------------
  // Next-state and registered-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    grp_d    = grp_q;
    settle_d = settle_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    count_d  = count_q;
`ifdef ONES_CHECK_EN
    err_d    = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          // Group 0 goes straight onto the cell; the shift register keeps
          // the groups that follow it, lowest group in the low bits.
          grp_d    = w_padded[2:0];
          shift_d  = w_padded >> 3;
          acc_d    = '0;
          idx_d    = '0;
          settle_d = SW'(SETTLE - 1);
          state_d  = S_WAIT;
        end
      end

      S_WAIT: begin
        // Loading SETTLE-1 and sampling on the edge after the counter hits
        // zero gives exactly SETTLE+1 edges of hold before each sample.
        if (settle_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end

      S_SAMPLE: begin
        acc_d = acc_q + w_sample;
`ifdef ONES_CHECK_EN
        if ({cnt_y1, cnt_y0} != w_grp_ones) begin
          err_d = 1'b1;
        end
`endif
        if (w_last) begin
          count_d = acc_q + w_sample;
          grp_d   = 3'b000;
          state_d = S_DONE;
        end else begin
          grp_d    = shift_q[2:0];
          shift_d  = shift_q >> 3;
          settle_d = SW'(SETTLE - 1);
          idx_d    = idx_q + 1'b1;
          state_d  = S_WAIT;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake flags are registered copies decoded from the next state, so
    // there is no combinational path from out_ready to in_ready.
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_WAIT) || (state_d == S_SAMPLE);
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      grp_q       <= 3'b000;
      settle_q    <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ONES_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      grp_q       <= grp_d;
      settle_q    <= settle_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef ONES_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_count = count_q;
  assign busy      = busy_q;
  assign cnt_a     = grp_q[0];
  assign cnt_b     = grp_q[1];
  assign cnt_c     = grp_q[2];
`ifdef ONES_CHECK_EN
  assign err       = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ones_count_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ones_count_sequencer
// Description : Self-checking bench for ones_count_sequencer with a
//               behavioural ones-counter cell and a popcount reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ones_count_sequencer;

  localparam int WIDTH  = 12;
  localparam int SETTLE = 2;
  localparam int G      = (WIDTH + 2) / 3;
  localparam int CW     = $clog2(WIDTH + 1);
  localparam int LAT    = G * (SETTLE + 1);

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] in_data   = '0;
  logic             in_ready;
  logic             cnt_a, cnt_b, cnt_c;
  logic             cnt_y1, cnt_y0;
  logic             out_valid;
  logic [CW-1:0]    out_count;
  logic             busy;
`ifdef ONES_CHECK_EN
  logic             err;
`endif

  logic             force_y0_low = 1'b0;
  logic [1:0]       cell_sum;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  // Behavioural ones-counter cell
  assign cell_sum = 2'(cnt_a) + 2'(cnt_b) + 2'(cnt_c);
  assign cnt_y1   = cell_sum[1];
  assign cnt_y0   = force_y0_low ? 1'b0 : cell_sum[0];

  ones_count_sequencer #(
    .WIDTH  (WIDTH),
    .SETTLE (SETTLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b),
    .cnt_c     (cnt_c),
    .cnt_y1    (cnt_y1),
    .cnt_y0    (cnt_y0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
`ifdef ONES_CHECK_EN
    ,
    .err       (err)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    n_checks++;
    if ({in_ready, out_valid, out_count, cnt_a, cnt_b, cnt_c, busy} !== {1'b1, 1'b0, CW'(0), 3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b vld=%b cnt=%0d abc=%b%b%b busy=%b, want rdy=1 vld=0 cnt=0 abc=000 busy=0",
               in_ready, out_valid, out_count, cnt_a, cnt_b, cnt_c, busy);
    end
`ifdef ONES_CHECK_EN
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: got %b want 0", err);
    end
`endif
  endtask

  // One full transaction: accept, per-cycle group/latency checks, result,
  // optional backpressure of `hold` cycles, then the output handshake.
  task automatic test_stream(input logic [WIDTH-1:0] d, input int hold);
    int            k;
    logic [3*G-1:0] padded;
    logic [2:0]    exp_grp;
    logic [CW-1:0] exp_cnt;

    padded = '0;
    padded[WIDTH-1:0] = d;
    exp_cnt = CW'($countones(d));

    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_timeout: in_ready=%b want 1", in_ready);
    end

    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;

    k = 0;
    while (out_valid !== 1'b1 && k < LAT + 5) begin
      if (k < LAT) begin
        exp_grp = padded[3*(k/(SETTLE+1)) +: 3];
        n_checks++;
        if ({cnt_c, cnt_b, cnt_a} !== exp_grp || busy !== 1'b1 || in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL group_drive word=%h cyc=%0d: got cba=%b busy=%b rdy=%b, want cba=%b busy=1 rdy=0",
                   d, k, {cnt_c, cnt_b, cnt_a}, busy, in_ready, exp_grp);
        end
      end
      step();
      k++;
    end

    n_checks++;
    if (k !== LAT) begin
      n_fail++;
      $display("FAIL latency word=%h: got %0d cycles want %0d", d, k, LAT);
    end
    n_checks++;
    if (out_count !== exp_cnt || {cnt_c, cnt_b, cnt_a} !== 3'b000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL result word=%h: got cnt=%0d cba=%b busy=%b, want cnt=%0d cba=000 busy=0",
               d, out_count, {cnt_c, cnt_b, cnt_a}, busy, exp_cnt);
    end

    for (int i = 0; i < hold; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_count !== exp_cnt || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold word=%h cyc=%0d: got vld=%b cnt=%0d rdy=%b, want vld=1 cnt=%0d rdy=0",
                 d, i, out_valid, out_count, in_ready, exp_cnt);
      end
    end

    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL handshake word=%h: got vld=%b rdy=%b, want vld=0 rdy=1", d, out_valid, in_ready);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_directed();
    test_stream(12'h000, 0);
    test_stream(12'hFFF, 0);
    test_stream(12'b101_011_110_001, 1);
    test_stream(12'h800, 0);
  endtask

  task automatic test_backpressure();
    int k;
    in_valid = 1'b1;
    in_data  = 12'h0F0;
    step();
    // Keep offering a different word while busy; it must be ignored.
    in_data = 12'hFFF;
    k = 0;
    while (out_valid !== 1'b1 && k < LAT + 5) begin
      step();
      k++;
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_count !== CW'(4)) begin
      n_fail++;
      $display("FAIL bp_result: got vld=%b cnt=%0d want vld=1 cnt=4", out_valid, out_count);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_count !== CW'(4) || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d: got vld=%b cnt=%0d rdy=%b want vld=1 cnt=4 rdy=0",
                 i, out_valid, out_count, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got rdy=%b vld=%b busy=%b want rdy=1 vld=0 busy=0",
               in_ready, out_valid, busy);
    end
    step();
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_stale_accept: got rdy=%b busy=%b want rdy=1 busy=0", in_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    test_stream(12'h3C5, 0);
    test_stream(12'hA5A, 0);
    test_stream(12'h001, 0);
  endtask

  task automatic test_reset_midop();
    in_valid = 1'b1;
    in_data  = 12'hFFF;
    step();
    in_valid = 1'b0;
    repeat (2 * (SETTLE + 1)) step();
    n_checks++;
    if ({cnt_c, cnt_b, cnt_a} !== 3'b111 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_pre: got cba=%b busy=%b want cba=111 busy=1", {cnt_c, cnt_b, cnt_a}, busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {cnt_c, cnt_b, cnt_a} !== 3'b000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset: got vld=%b rdy=%b cba=%b busy=%b want vld=0 rdy=1 cba=000 busy=0",
               out_valid, in_ready, {cnt_c, cnt_b, cnt_a}, busy);
    end
    test_stream(12'h007, 0);
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int n = 0; n < 20; n++) begin
      r = $urandom;
      test_stream(r[WIDTH-1:0], int'($urandom_range(0, 3)));
    end
  endtask

`ifdef ONES_CHECK_EN
  task automatic test_err();
    int k;
    force_y0_low = 1'b1;
    in_valid = 1'b1;
    in_data  = 12'h001;
    step();
    in_valid = 1'b0;
    repeat (SETTLE) step();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_early: got %b want 0", err);
    end
    step();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: got %b want 1", err);
    end
    k = 0;
    while (out_valid !== 1'b1 && k < LAT + 5) begin
      step();
      k++;
    end
    force_y0_low = 1'b0;
    n_checks++;
    if (out_count !== CW'(0)) begin
      n_fail++;
      $display("FAIL err_count: got %0d want 0", out_count);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b want 1", err);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %b want 0", err);
    end
  endtask
`endif

  // --------------------------------------------------------------------------
  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
`ifdef ONES_CHECK_EN
    test_err();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
